// File: rtl/checkbit_pkg.sv
// Shared definitions for the checkbit transmitter, receiver and checker.
// State encoding and parity-mode constants must stay identical across all three.
package checkbit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic FUN_EVEN = 1'b0;
    localparam logic FUN_ODD  = 1'b1;

endpackage

// File: rtl/checkbit_parity.sv
// Combinational check-bit generator: reduction XOR of the word, inverted for odd mode.
// Shared with the receive-side checker so both ends agree on the parity rule.
module checkbit_parity
    import checkbit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fun,
    output logic             par
);

    always_comb begin
        par = (^data) ^ (fun == FUN_ODD);
    end

endmodule

// File: rtl/checkbit_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, parity bit, stop bit.
// Each bit is held on txd for BIT_CYCLES clocks; txd is driven from a register.
module checkbit_tx
    import checkbit_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] date,
    input  logic             fun,
    input  logic             start,
    output logic             ready,
    output logic             txd,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    localparam int unsigned BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BTW = $clog2(WIDTH);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BIT_CYCLES - 1);
    localparam logic [BTW-1:0] BIT_LAST  = BTW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   baud_q,  baud_d;
    logic [BTW-1:0]   bit_q,   bit_d;
    logic             par_q,   par_d;
    logic             txd_q,   txd_d;
    logic             done_q,  done_d;
    logic             par_calc;
    logic             baud_last;

    checkbit_parity #(.WIDTH(WIDTH)) u_parity (
        .data (date),
        .fun  (fun),
        .par  (par_calc)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    // txd_d is the line level for the state being entered, so txd_q lines up with state_q.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        par_d   = par_q;
        txd_d   = 1'b1;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = date;
                    par_d   = par_calc;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end

            S_START: begin
                txd_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                txd_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_PAR;
                        txd_d   = par_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_PAR: begin
                txd_d = par_q;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                txd_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q != S_IDLE);
    assign txd    = txd_q;
    assign done   = done_q;
    assign parity = par_q;

endmodule

// File: tb/tb_checkbit_tx.sv
// Bench for checkbit_tx: one instance at BIT_CYCLES=1 and one at BIT_CYCLES=4.
// Expected line bits are queued at accept and popped as the frame is sampled.
module tb_checkbit_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, fun1, ready1, txd1, busy1, done1, par1;
    logic [31:0] date1;
    logic        start4, fun4, ready4, txd4, busy4, done4, par4;
    logic [31:0] date4;

    always #5 clk = ~clk;

    checkbit_tx #(.WIDTH(32), .BIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .date(date1), .fun(fun1), .start(start1),
        .ready(ready1), .txd(txd1), .busy(busy1), .done(done1), .parity(par1)
    );

    checkbit_tx #(.WIDTH(32), .BIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .date(date4), .fun(fun4), .start(start4),
        .ready(ready4), .txd(txd4), .busy(busy4), .done(done4), .parity(par4)
    );

    typedef struct {
        logic [31:0] d;
        logic        f;
        logic        p;
        int          sel;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic o_txd(input int s);   return s != 0 ? txd4   : txd1;   endfunction
    function automatic logic o_ready(input int s); return s != 0 ? ready4 : ready1; endfunction
    function automatic logic o_busy(input int s);  return s != 0 ? busy4  : busy1;  endfunction
    function automatic logic o_done(input int s);  return s != 0 ? done4  : done1;  endfunction
    function automatic logic o_par(input int s);   return s != 0 ? par4   : par1;   endfunction

    task automatic drive(input int s, input logic st, input logic [31:0] d, input logic f);
        if (s != 0) begin start4 = st; date4 = d; fun4 = f; end
        else        begin start1 = st; date1 = d; fun1 = f; end
    endtask

    task automatic push_frame(input int s, input logic [31:0] d, input logic p);
        int bc;
        bc = (s != 0) ? 4 : 1;
        for (int k = 0; k < bc; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < bc; k++) exp_q.push_back(d[i]);
        for (int k = 0; k < bc; k++) exp_q.push_back(p);
        for (int k = 0; k < bc; k++) exp_q.push_back(1'b1);
    endtask

    // Request at a negedge, queue the frame at the accepting edge, then scramble inputs.
    task automatic accept(input int s, input logic [31:0] d, input logic f, input logic p);
        @(negedge clk);
        drive(s, 1'b1, d, f);
        @(posedge clk);
        push_frame(s, d, p);
        #1;
        drive(s, 1'b0, ~d, ~f);
    endtask

    // Called just after the accepting edge; samples every frame cycle then the done cycle.
    task automatic expect_frame(input int s, input logic p, input logic noise);
        int n;
        n = 35 * ((s != 0) ? 4 : 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no expected bit, required one at %0t", $time);
            end else begin
                check("txd", o_txd(s), exp_q.pop_front());
            end
            check("busy_in_frame", o_busy(s), 1'b1);
            check("ready_in_frame", o_ready(s), 1'b0);
            check("done_in_frame", o_done(s), 1'b0);
            if (k == 0) check("parity_latched", o_par(s), p);
            if (noise) drive(s, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        if (noise) drive(s, 1'b0, 32'h0, 1'b0);
        check("done_pulse", o_done(s), 1'b1);
        check("ready_at_done", o_ready(s), 1'b1);
        check("busy_at_done", o_busy(s), 1'b0);
        check("txd_at_done", o_txd(s), 1'b1);
        check("parity_hold", o_par(s), p);
    endtask

    initial begin
        vecs.push_back('{d: 32'h0000_0109, f: 1'b0, p: 1'b1, sel: 0});
        vecs.push_back('{d: 32'h0000_0109, f: 1'b1, p: 1'b0, sel: 0});
        vecs.push_back('{d: 32'hFFFF_FFFF, f: 1'b0, p: 1'b0, sel: 1});
        vecs.push_back('{d: 32'h0000_0000, f: 1'b0, p: 1'b0, sel: 0});
        vecs.push_back('{d: 32'h0000_0000, f: 1'b1, p: 1'b1, sel: 1});
        vecs.push_back('{d: 32'h8000_0001, f: 1'b1, p: 1'b1, sel: 0});
        vecs.push_back('{d: 32'hA5A5_A5A5, f: 1'b1, p: 1'b1, sel: 1});
        vecs.push_back('{d: 32'h0000_0007, f: 1'b0, p: 1'b1, sel: 0});

        reset = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_txd", o_txd(s), 1'b1);
            check("rst_ready", o_ready(s), 1'b1);
            check("rst_busy", o_busy(s), 1'b0);
            check("rst_done", o_done(s), 1'b0);
            check("rst_parity", o_par(s), 1'b0);
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check("idle_txd", o_txd(s), 1'b1);
                check("idle_ready", o_ready(s), 1'b1);
                check("idle_busy", o_busy(s), 1'b0);
                check("idle_done", o_done(s), 1'b0);
            end
        end

        foreach (vecs[i]) begin
            accept(vecs[i].sel, vecs[i].d, vecs[i].f, vecs[i].p);
            expect_frame(vecs[i].sel, vecs[i].p, vecs[i].sel != 0);
        end

        // Back-to-back: start held through the done cycle.
        @(negedge clk);
        drive(0, 1'b1, 32'h1, 1'b0);
        @(posedge clk);
        push_frame(0, 32'h1, 1'b1);
        #1;
        date1 = 32'h3;
        expect_frame(0, 1'b1, 1'b0);
        @(posedge clk);
        push_frame(0, 32'h3, 1'b0);
        #1;
        start1 = 1'b0;
        expect_frame(0, 1'b0, 1'b0);

        // Reset during data bit 10 (bit 10 of the word is 0, so txd must visibly rise).
        accept(0, 32'hFFFF_FBFF, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("pre_reset_txd", txd1, exp_q.pop_front());
        end
        #2 reset = 1'b0;
        #1;
        check("async_txd", txd1, 1'b1);
        check("async_ready", ready1, 1'b1);
        check("async_busy", busy1, 1'b0);
        check("async_done", done1, 1'b0);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("in_reset_done", done1, 1'b0);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_reset_ready", ready1, 1'b1);
            check("post_reset_done", done1, 1'b0);
            check("post_reset_txd", txd1, 1'b1);
        end
        accept(0, 32'h1234_5678, 1'b1, 1'b0);
        expect_frame(0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/checkbit_tx.md
Name: checkbit_tx

Overview:
Transmit-side counterpart of the bitcheck checker. It accepts a parallel word and a parity mode, computes the check bit, and shifts the word out serially.
Frame order is start bit, data bits LSB first, parity bit, stop bit, on a single-wire line.
It sits between the datapath producing words and the serial link whose far end runs the bit check.

Parameters:
WIDTH, 32, data word width in bits (>=2)
BIT_CYCLES, 1, clock cycles each serial bit is held on txd (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
date  input  WIDTH  parallel word to send; sampled only on accept
fun  input  1  parity mode: 0 = even (total ones incl. parity even), 1 = odd; sampled on accept
start  input  1  request to send; accepted when start && ready
ready  output  1  high only in IDLE; block can accept a word
txd  output  1  serial line, idle high
busy  output  1  high from the cycle after accept until the end of the stop bit
done  output  1  one-cycle pulse in the cycle after the stop bit completes
parity  output  1  registered parity bit of the word currently or last sent

Behaviour:
- Reset values: ready=1, txd=1, busy=0, done=0, parity=0. State is IDLE, shift register and counters are 0.
- Reset is asynchronous. Asserting reset mid-frame aborts the frame immediately: txd=1, state IDLE, no done pulse.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - On start && ready, latch date into the shift register and compute parity = (^date) ^ fun.
  - Go to START. ready drops to 0 the next cycle.
- START: txd=0 for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - txd = shift[0]; shift right every BIT_CYCLES cycles.
  - A bit counter runs 0..WIDTH-1. After bit WIDTH-1 has been held its full period, go to PAR.
- PAR: txd = parity for BIT_CYCLES cycles, then go to STOP.
- STOP:
  - txd=1 for BIT_CYCLES cycles.
  - Then return to IDLE with done=1 for exactly that first IDLE cycle.
  - ready=1 in that same cycle.
- Timing:
  - txd is registered; the first start-bit cycle is the cycle after accept.
  - Frame length is exactly (WIDTH+3)*BIT_CYCLES cycles.
  - Back-to-back: start held high in the done cycle is accepted. That frame's start bit follows with no extra idle cycle.
- start while busy is ignored. Changes to date/fun after accept do not affect the frame in flight.
- The bit-period counter is ceil(log2(BIT_CYCLES)) wide (min 1) and wraps to 0 at BIT_CYCLES-1.
- The bit counter is ceil(log2(WIDTH)) wide.
- With BIT_CYCLES=1, every state lasts exactly one cycle per bit.
- parity holds its value after the frame until the next accept.

Decomposition:
- Shared package checkbit_pkg:
  - state encoding constants S_IDLE=3'd0, S_START=3'd1, S_DATA=3'd2, S_PAR=3'd3, S_STOP=3'd4;
  - parity mode constants FUN_EVEN=1'b0, FUN_ODD=1'b1.
  - The receiver and checker reuse the same package.
- One sub-module, checkbit_parity: a combinational WIDTH-bit reduction plus the fun select. The tx and the existing checker share it.
- The FSM, counters and shift register stay in checkbit_tx.

Test Plan:
- Reset, then idle 5 cycles -> txd=1, ready=1, busy=0, done=0 throughout.
- WIDTH=32, BIT_CYCLES=1, date=32'h00000109 (3 ones), fun=0, start for 1 cycle:
  - parity=1;
  - txd sequence 0, 1,0,0,1,0,0,0,0,1, 23×0, 1 (parity), 1 (stop);
  - done pulses at cycle 36 after accept.
- Same word with fun=1 -> parity=0. Parity slot on txd is 0; all other bits are identical.
- BIT_CYCLES=4, date=32'hFFFFFFFF, fun=0:
  - every bit held 4 cycles, parity=0;
  - frame is 140 cycles;
  - start pulses during busy have no effect.
- start held high continuously with date=32'h1 then 32'h3 -> second frame's start bit immediately follows the first frame's stop bit, with done and accept in the same cycle.
- Assert reset (low) during DATA bit 10, release after 2 cycles:
  - txd=1 asynchronously, no done pulse;
  - ready=1 after release;
  - a new start sends a correct full frame.
